// File: rtl/icache_refill_responder.sv
// icache_refill_responder: critical-word-first line refill from backing memory with per-word timeout
module icache_refill_responder #(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic [31:0]                   req_addr,
    output logic                          req_ready,
    output logic                          mem_rd_en,
    output logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_rvalid,
    output logic                          resp_valid,
    output logic [$clog2(LINE_WORDS)-1:0] resp_idx,
    output logic [31:0]                   resp_data,
    output logic                          resp_last,
    output logic                          refill_err
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0]   LAST = (IW + 1)'(LINE_WORDS - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
    logic [1:0]     state;
    logic [29-IW:0] line;
    logic [IW-1:0]  start, idx;
    logic [IW:0]    cnt;
    logic [TW-1:0]  wcnt;
    logic           unused_addr;
    assign unused_addr = ^req_addr[1:0];
    assign idx       = start + cnt[IW-1:0];
    assign req_ready = state == IDLE && reset;
    assign mem_rd_en = state == ISSUE;
    assign mem_addr  = mem_rd_en ? {line, idx, 2'b00} : '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            line       <= '0;
            start      <= '0;
            cnt        <= '0;
            wcnt       <= '0;
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
            refill_err <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            refill_err <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    line  <= req_addr[31:IW+2];
                    start <= req_addr[IW+1:2];
                    cnt   <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: if (mem_rvalid) begin
                    resp_valid <= 1'b1;
                    resp_data  <= mem_rdata;
                    resp_idx   <= idx;
                    resp_last  <= cnt == LAST;
                    cnt        <= cnt + (IW + 1)'(1);
                    state      <= cnt == LAST ? DONE : ISSUE;
                end else if (wcnt == TMAX) begin
                    refill_err <= 1'b1;
                    state      <= IDLE;
                end else begin
                    wcnt <= wcnt + TW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_responder.sv
// tb_icache_refill_responder: table-driven refill vectors plus reset and spurious-input sequences
module tb_icache_refill_responder;
    localparam logic [31:0] K = 32'hA5A5_A5A5;
    typedef struct packed {
        logic [31:0]      addr;
        logic [3:0][3:0]  lat;
        logic [3:0][31:0] maddr;
        logic [3:0][1:0]  idx;
        logic [2:0]       nwords;
        logic [7:0]       last_at;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic        resp_valid;
    logic [1:0]  resp_idx;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        refill_err;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    vec_t        tv[5];
    icache_refill_responder dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .resp_valid(resp_valid),
        .resp_idx(resp_idx), .resp_data(resp_data), .resp_last(resp_last),
        .refill_err(refill_err)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic chk_zero_outputs(input logic ready_exp);
        chk("rst_req_ready", 32'(req_ready), 32'(ready_exp));
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_last", 32'(resp_last), 0);
        chk("rst_refill_err", 32'(refill_err), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_idx", 32'(resp_idx), 0);
    endtask
    task automatic run_refill(input vec_t v, input bit hold);
        int c, acc, nrd, nresp, cd, err_c, rdy_c, last_c;
        logic [31:0] pa;
        bit err;
        err = v.nwords != 3'd4;
        req_addr = v.addr;
        req_valid = 1'b1;
        c = 0;
        while (!req_ready && c < 20) begin
            step();
            c++;
        end
        chk("accept_ready", 32'(req_ready), 1);
        acc = cyc;
        step();
        if (!hold) req_valid = 1'b0;
        nrd = 0; nresp = 0; cd = 0; err_c = 0; rdy_c = 0; last_c = 0; pa = '0;
        while (rdy_c == 0 && cyc - acc < 200) begin
            if (cd > 0) begin
                cd--;
                mem_rvalid = cd == 0;
                mem_rdata = cd == 0 ? pa ^ K : 32'h0;
            end else begin
                mem_rvalid = 1'b0;
            end
            if (mem_rd_en) begin
                chk("one_outstanding", 32'(cd), 0);
                if (nrd < 4) begin
                    chk("mem_addr", mem_addr, v.maddr[nrd]);
                    cd = int'(v.lat[nrd]);
                end
                pa = mem_addr;
                nrd++;
            end
            if (resp_valid) begin
                if (nresp < 4) begin
                    chk("resp_idx", 32'(resp_idx), 32'(v.idx[nresp]));
                    chk("resp_data", resp_data, v.maddr[nresp] ^ K);
                end
                chk("resp_last", 32'(resp_last), 32'(nresp == 3));
                if (nresp == 3) last_c = cyc - acc;
                nresp++;
            end
            if (refill_err) err_c = cyc - acc;
            if (req_ready) rdy_c = cyc - acc;
            else step();
        end
        mem_rvalid = 1'b0;
        chk("rd_count", 32'(nrd), err ? 3 : 4);
        chk("resp_count", 32'(nresp), 32'(v.nwords));
        if (err) begin
            chk("err_cycle", 32'(err_c), 32'(v.last_at));
            chk("ready_after_err", 32'(rdy_c), 32'(v.last_at));
            step();
            chk("err_one_pulse", 32'(refill_err), 0);
        end else begin
            chk("last_latency", 32'(last_c), 32'(v.last_at));
            chk("ready_after_done", 32'(rdy_c), 32'(v.last_at) + 1);
            chk("no_err", 32'(err_c), 0);
        end
    endtask
    initial begin
        tv[0] = '{32'h0000_1008, {4'd1, 4'd1, 4'd1, 4'd1},
                  {32'h1004, 32'h1000, 32'h100C, 32'h1008}, {2'd1, 2'd0, 2'd3, 2'd2}, 3'd4, 8'd9};
        tv[1] = '{32'h0000_2003, {4'd1, 4'd1, 4'd1, 4'd1},
                  {32'h200C, 32'h2008, 32'h2004, 32'h2000}, {2'd3, 2'd2, 2'd1, 2'd0}, 3'd4, 8'd9};
        tv[2] = '{32'h0000_3FFC, {4'd2, 4'd10, 4'd1, 4'd3},
                  {32'h3FF8, 32'h3FF4, 32'h3FF0, 32'h3FFC}, {2'd2, 2'd1, 2'd0, 2'd3}, 3'd4, 8'd21};
        tv[3] = '{32'h8000_0014, {4'd7, 4'd1, 4'd5, 4'd2},
                  {32'h8000_0010, 32'h8000_001C, 32'h8000_0018, 32'h8000_0014},
                  {2'd0, 2'd3, 2'd2, 2'd1}, 3'd4, 8'd20};
        tv[4] = '{32'h0000_4004, {4'd0, 4'd0, 4'd1, 4'd1},
                  {32'h4000, 32'h400C, 32'h4008, 32'h4004}, {2'd0, 2'd3, 2'd2, 2'd1}, 3'd2, 8'd70};
        step();
        step();
        chk_zero_outputs(1'b0);
        reset = 1'b1;
        step();
        chk("ready_after_release", 32'(req_ready), 1);
        for (int i = 0; i < 5; i++) run_refill(tv[i], 1'b0);
        req_addr = 32'h0000_5000;
        req_valid = 1'b1;
        chk("mid_accept_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        chk("mid_rd0", 32'(mem_rd_en), 1);
        chk("mid_addr0", mem_addr, 32'h5000);
        step();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_rvalid = 1'b0;
        chk("mid_resp0", 32'(resp_valid), 1);
        chk("mid_addr1", mem_addr, 32'h5004);
        step();
        reset = 1'b0;
        step();
        chk_zero_outputs(1'b0);
        reset = 1'b1;
        step();
        chk("mid_ready", 32'(req_ready), 1);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid_resp", 32'(resp_valid), 0);
        chk("late_rvalid_err", 32'(refill_err), 0);
        chk("late_rvalid_rd", 32'(mem_rd_en), 0);
        run_refill(tv[0], 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_resp", 32'(resp_valid), 0);
        chk("idle_rvalid_ready", 32'(req_ready), 1);
        chk("idle_rvalid_rd", 32'(mem_rd_en), 0);
        run_refill(tv[3], 1'b1);
        run_refill(tv[1], 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
